// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM address and
// registers the returned word into the IF/ID register. Optional macro: FETCH_CNT_EN.
module inst_fetch_stage #(
    parameter int              PC_W     = 5,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst_in,
    input  logic              id_ready,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    input  logic              start,
    output logic [INST_W-1:0] if_id_inst,
    output logic [PC_W-1:0]   if_id_pc,
    output logic              if_id_valid,
    output logic              halted,
    output logic [1:0]        state_dbg
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] redirect_tgt;

    // Handshake: if_id_* carry a real instruction when if_id_valid=1, and decode
    // consumes it on any edge where id_ready=1; with id_ready=0 everything holds.
    // Redirect targets are forced word-aligned by clearing the two low bits.
    assign redirect_tgt = redirect_pc & ~(PC_W'(3));
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            if_id_inst  <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef FETCH_CNT_EN
            fetch_cnt   <= 16'd0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                    if (redirect_en) begin
                        pc          <= redirect_tgt;
                        if_id_valid <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (redirect_en) begin
                        // Redirect wins over both stall and halt_req.
                        pc          <= redirect_tgt;
                        if_id_valid <= 1'b0;
                    end else begin
                        if (halt_req) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                        if (id_ready) begin
                            if_id_inst  <= inst_in;
                            if_id_pc    <= pc;
                            if_id_valid <= 1'b1;
                            pc          <= pc + PC_W'(4);
`ifdef FETCH_CNT_EN
                            fetch_cnt   <= fetch_cnt + 16'd1;
`endif
                        end
                    end
                end

                ST_HALT: begin
                    // PC frozen; the held instruction drains once decode accepts it.
                    if (redirect_en) begin
                        pc          <= redirect_tgt;
                        if_id_valid <= 1'b0;
                    end else if (id_ready) begin
                        if_id_valid <= 1'b0;
                    end
                    if (start) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed, table-driven bench for inst_fetch_stage with a combinational ROM model.
module tb_inst_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [4:0]  pc;
    logic [31:0] inst_in;
    logic        id_ready;
    logic        redirect_en;
    logic [4:0]  redirect_pc;
    logic        halt_req;
    logic        start;
    logic [31:0] if_id_inst;
    logic [4:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [1:0]  state_dbg;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    inst_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .inst_in     (inst_in),
        .id_ready    (id_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .start       (start),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .state_dbg   (state_dbg)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ROM word n is tagged so stale or shifted words are visible.
    function automatic logic [31:0] rom_word(input logic [4:0] a);
        return 32'hC0DE_0000 | {29'd0, a[4:2]};
    endfunction

    assign inst_in = rom_word(pc);

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [4:0]  rpc;
        logic        hreq;
        logic        st;
        logic        fetch;
        logic [4:0]  pc;
        logic [4:0]  ipc;
        logic [31:0] inst;
        logic        vld;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [4:0] rpc,
                                input logic hreq, input logic st, input logic fetch,
                                input logic [4:0] epc, input logic [4:0] eipc,
                                input logic [31:0] einst, input logic evld, input logic ehlt);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.hreq = hreq; v.st = st;
        v.fetch = fetch; v.pc = epc; v.ipc = eipc; v.inst = einst; v.vld = evld; v.hlt = ehlt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- driver: drive inputs now, compare #1 after the next rising edge ----
    task automatic apply(input vec_t v, input int idx);
        id_ready    = v.rdy;
        redirect_en = v.redir;
        redirect_pc = v.rpc;
        halt_req    = v.hreq;
        start       = v.st;
        @(posedge clk);
        #1;
        if (v.fetch) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        check($sformatf("v%0d pc", idx),          {27'd0, pc},          {27'd0, v.pc});
        check($sformatf("v%0d if_id_pc", idx),    {27'd0, if_id_pc},    {27'd0, v.ipc});
        check($sformatf("v%0d if_id_inst", idx),  if_id_inst,           v.inst);
        check($sformatf("v%0d if_id_valid", idx), {31'd0, if_id_valid}, {31'd0, v.vld});
        check($sformatf("v%0d halted", idx),      {31'd0, halted},      {31'd0, v.hlt});
`ifdef FETCH_CNT_EN
        check($sformatf("v%0d fetch_cnt", idx),   {16'd0, fetch_cnt},   exp_cnt);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc"},          {27'd0, pc},          32'd0);
        check({tag, " if_id_pc"},    {27'd0, if_id_pc},    32'd0);
        check({tag, " if_id_inst"},  if_id_inst,           32'd0);
        check({tag, " if_id_valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, " halted"},      {31'd0, halted},      32'd0);
        check({tag, " state"},       {30'd0, state_dbg},   32'd0);
`ifdef FETCH_CNT_EN
        check({tag, " fetch_cnt"},   {16'd0, fetch_cnt},   32'd0);
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        id_ready    = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 5'd0;
        halt_req    = 1'b0;
        start       = 1'b0;

        //          rdy red rpc   hrq st  fch  pc     ipc    inst          vld hlt
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 0, 5'd0,  5'd0,  32'd0,        0, 0)); // BOOT
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd4,  5'd0,  rom_word(0),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd8,  5'd4,  rom_word(4),  1, 0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 0, 5'd8,  5'd4,  rom_word(4),  1, 0)); // stall x3
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 0, 5'd8,  5'd4,  rom_word(4),  1, 0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 0, 5'd8,  5'd4,  rom_word(4),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd12, 5'd8,  rom_word(8),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  1, 0, 1, 5'd16, 5'd12, rom_word(12), 1, 1)); // halt_req
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 0, 5'd16, 5'd12, rom_word(12), 0, 1));
        vecs.push_back(mk(1, 0, 5'd0,  1, 0, 0, 5'd16, 5'd12, rom_word(12), 0, 1)); // ignored
        vecs.push_back(mk(1, 0, 5'd0,  0, 1, 0, 5'd16, 5'd12, rom_word(12), 0, 0)); // start
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd20, 5'd16, rom_word(16), 1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd24, 5'd20, rom_word(20), 1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd28, 5'd24, rom_word(24), 1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd0,  5'd28, rom_word(28), 1, 0)); // wrap
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd4,  5'd0,  rom_word(0),  1, 0));
        vecs.push_back(mk(0, 1, 5'd22, 0, 0, 0, 5'd20, 5'd0,  rom_word(0),  0, 0)); // redirect+stall
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 0, 5'd20, 5'd0,  rom_word(0),  0, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd24, 5'd20, rom_word(20), 1, 0));
        vecs.push_back(mk(1, 1, 5'd7,  1, 0, 0, 5'd4,  5'd20, rom_word(20), 0, 0)); // redirect beats halt
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd8,  5'd4,  rom_word(4),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  1, 0, 1, 5'd12, 5'd8,  rom_word(8),  1, 1)); // halt
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 0, 5'd12, 5'd8,  rom_word(8),  1, 1)); // held in HALT
        vecs.push_back(mk(0, 1, 5'd31, 0, 0, 0, 5'd28, 5'd8,  rom_word(8),  0, 1)); // redirect in HALT
        vecs.push_back(mk(1, 0, 5'd0,  0, 1, 0, 5'd28, 5'd8,  rom_word(8),  0, 0)); // start
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd0,  5'd28, rom_word(28), 1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd4,  5'd0,  rom_word(0),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd8,  5'd4,  rom_word(4),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd12, 5'd8,  rom_word(8),  1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd16, 5'd12, rom_word(12), 1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 1, 5'd20, 5'd16, rom_word(16), 1, 0));

        // ---- reset block ----
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // ---- asynchronous reset mid-run at pc=20, checked before the next edge ----
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect during BOOT, then the first fetch from the aligned target.
        apply(mk(1, 1, 5'd13, 0, 0, 0, 5'd12, 5'd0,  32'd0,         0, 0), 100);
        apply(mk(1, 0, 5'd0,  0, 0, 1, 5'd16, 5'd12, rom_word(12),  1, 0), 101);
        apply(mk(1, 0, 5'd0,  0, 0, 1, 5'd20, 5'd16, rom_word(16),  1, 0), 102);
        check("post_reset state", {30'd0, state_dbg}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Fetch stage that sits directly upstream of the Inst_Rom instruction ROM and feeds the decode stage.
- Owns the program counter and drives the ROM address.
- Captures the ROM's combinational instruction word into an IF/ID pipeline register.
- Supports stall, redirect (branch/jump) and halt/resume, with a small control FSM.

Parameters:
- PC_W, 5, width of the PC and ROM address (byte address; word-aligned, step 4).
- INST_W, 32, instruction width.
- RESET_PC, 5'd0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- pc  output  PC_W  current fetch address; drives Inst_Rom pc.
- inst_in  input  INST_W  instruction word returned combinationally by Inst_Rom for pc.
- id_ready  input  1  decode can accept this cycle; 0 = stall.
- redirect_en  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  PC_W  redirect target; bits [1:0] ignored.
- halt_req  input  1  request to stop fetching.
- start  input  1  resume fetching from HALT.
- if_id_inst  output  INST_W  registered instruction to decode.
- if_id_pc  output  PC_W  PC of if_id_inst.
- if_id_valid  output  1  if_id_inst/if_id_pc hold a real instruction.
- halted  output  1  FSM is in HALT.

Behaviour:
- Clocking: one clock domain (clk); rst_n is asynchronous, active-low. The reset assertion clears all state immediately; deassertion is sampled at the next clk edge.
- Reset values:
  - pc = RESET_PC
  - if_id_inst = 0, if_id_pc = 0
  - if_id_valid = 0
  - halted = 0
  - FSM = BOOT
- FSM states are BOOT, RUN and HALT.
  - BOOT: one cycle; if_id_valid stays 0, pc unchanged; unconditionally goes to RUN.
  - RUN: normal fetch. halt_req=1 (with no redirect) moves to HALT at the next edge; that edge still performs its normal fetch/stall action.
  - HALT: pc frozen and halted=1. When id_ready=1, if_id_valid clears to 0; the register contents are kept. start=1 returns to RUN next edge, fetching from the held pc. halt_req is ignored in HALT.
- Fetch latency: pc to inst_in is combinational. inst_in is captured at the edge ending the cycle, so if_id_* is valid 1 cycle after pc presents an address.
- RUN edge priority, highest first:
  1. redirect_en=1:
     - pc <= {redirect_pc[PC_W-1:2], 2'b00}
     - if_id_valid <= 0 (flush the wrong-path instruction)
     - if_id_inst/if_id_pc unchanged
     - Applies even when id_ready=0; redirect overrides stall and halt_req.
  2. id_ready=0 (stall): pc and all if_id_* hold.
  3. Otherwise:
     - if_id_inst <= inst_in, if_id_pc <= pc, if_id_valid <= 1
     - pc <= pc + 4, modulo 2^PC_W
- Wrap-around: with PC_W=5, 28+4 = 0. No error is flagged.
- redirect_en in BOOT or HALT: pc is loaded with the aligned target and if_id_valid cleared. The state transition rules are otherwise unchanged.
- Reset mid-operation: all state returns to reset values at once, regardless of FSM state or pending redirect.

Optional Feature:
- Macro: FETCH_CNT_EN.
- Defined:
  - Adds output fetch_cnt [15:0], reset to 0.
  - Increments by 1 on every edge that loads if_id_valid <= 1.
  - Wraps 16'hFFFF -> 0.
  - Holds on stall, redirect and HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, id_ready=1, ROM word n = n: pc goes 0,0,4,8,... (BOOT holds one cycle). if_id_valid first rises 2 edges after release with if_id_pc=0, if_id_inst=ROM[0].
- Run to wrap: after if_id_pc=28 the next if_id_pc=0. pc sequence 24,28,0,4 with no gap in if_id_valid.
- Stall: id_ready=0 for 3 cycles while pc=8. pc stays 8 and if_id_pc stays 4 for 3 cycles; on release if_id_pc=8, then 12.
- Redirect with stall: id_ready=0, redirect_en=1, redirect_pc=5'd22. Next edge pc=20, if_id_valid=0; then if_id_pc=20 once id_ready=1.
- Halt/resume: halt_req pulse at pc=12. Next edge halted=1, pc=16 frozen, if_id_valid drops to 0 the following edge. start pulse gives halted=0 and if_id_pc=16 valid one edge later.
- Async reset mid-run at pc=20: pc=0, if_id_valid=0, halted=0 immediately, before the next clk edge. With FETCH_CNT_EN, fetch_cnt=0 and it counts exactly the if_id_valid loads thereafter.
